// File: rtl/bin_to_bcd_serial_pkg.sv
// Shared widths, FSM states and result payload for the serial binary-to-BCD converter.
package bin_to_bcd_serial_pkg;

    localparam int unsigned BIN_W      = 8;
    localparam int unsigned DIGITS     = 3;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned ITER_CNT_W = 3;
    localparam int unsigned BCD_FLD_W  = DIGITS * BCD_W;
    localparam int unsigned SCRATCH_W  = BCD_FLD_W + BIN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [BCD_W-1:0] hundreds;
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd_digits_t;

endpackage

// File: rtl/bin_to_bcd_serial_if.sv
// Operand/result handshake bundle for bin_to_bcd_serial.
interface bin_to_bcd_serial_if;
    import bin_to_bcd_serial_pkg::*;

    logic [BIN_W-1:0] bin_in;
    logic             in_valid;
    logic             in_ready;
    logic [BCD_W-1:0] bcd_hundreds;
    logic [BCD_W-1:0] bcd_tens;
    logic [BCD_W-1:0] bcd_ones;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output bin_in, in_valid, out_ready,
        input  in_ready, bcd_hundreds, bcd_tens, bcd_ones, out_valid, busy
    );

    modport slave (
        input  bin_in, in_valid, out_ready,
        output in_ready, bcd_hundreds, bcd_tens, bcd_ones, out_valid, busy
    );
endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more before the shift.
module bcd_digit_adjust
    import bin_to_bcd_serial_pkg::*;
(
    input  logic [BCD_W-1:0] nib_in,
    output logic [BCD_W-1:0] nib_out_c
);
    always_comb begin
        nib_out_c = nib_in;
        if (nib_in >= BCD_W'(5)) nib_out_c = nib_in + BCD_W'(3);
    end
endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial 8-bit binary to 3-digit BCD converter (shift-and-add-3), one bit per enabled cycle.
module bin_to_bcd_serial
    import bin_to_bcd_serial_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    bin_to_bcd_serial_if.slave    bus
);
    state_t                  state;
    logic [ITER_CNT_W-1:0]   iter_cnt;
    logic [SCRATCH_W-1:0]    scratch;
    bcd_digits_t             digits;
    logic [BCD_FLD_W-1:0]    adj_c;
    logic [SCRATCH_W-1:0]    shifted_c;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_digit_adjust u_adj (
            .nib_in    (scratch[BIN_W + d*BCD_W +: BCD_W]),
            .nib_out_c (adj_c[d*BCD_W +: BCD_W])
        );
    end

    // The top adjusted bit can never be set for an 8-bit operand; truncation drops it.
    assign shifted_c = SCRATCH_W'({adj_c, scratch[BIN_W-1:0]} << 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            iter_cnt <= '0;
            scratch  <= '0;
            digits   <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        scratch  <= {BCD_FLD_W'(0), bus.bin_in};
                        iter_cnt <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch  <= shifted_c;
                    iter_cnt <= iter_cnt + ITER_CNT_W'(1);
                    if (iter_cnt == ITER_CNT_W'(BIN_W - 1)) begin
                        digits <= bcd_digits_t'(shifted_c[SCRATCH_W-1:BIN_W]);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = (state == IDLE);
    assign bus.out_valid    = (state == DONE);
    assign bus.busy         = (state == SHIFT);
    assign bus.bcd_hundreds = digits.hundreds;
    assign bus.bcd_tens     = digits.tens;
    assign bus.bcd_ones     = digits.ones;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Self-checking bench for bin_to_bcd_serial: vector table, corner sequences and a full sweep.
module tb_bin_to_bcd_serial;
    import bin_to_bcd_serial_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    int   errors = 0;
    int   checks = 0;

    bin_to_bcd_serial_if bus ();

    bin_to_bcd_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bin;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
    } vec_t;

    vec_t        vecs [8];
    bcd_digits_t exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bcd_digits_t model(input int v);
        bcd_digits_t r;
        r.hundreds = 4'(v / 100);
        r.tens     = 4'((v / 10) % 10);
        r.ones     = 4'(v % 10);
        return r;
    endfunction

    function automatic bcd_digits_t out_digits();
        bcd_digits_t r;
        r.hundreds = bus.bcd_hundreds;
        r.tens     = bus.bcd_tens;
        r.ones     = bus.bcd_ones;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept v, optionally pause ena / inject a stray operand,
    // hold the result for 'hold' cycles, then handshake it away.
    task automatic do_op(input logic [7:0] v, input bcd_digits_t exp, input int off_at,
                         input int off_len, input bit inject, input int hold, input int exp_lat);
        int k;
        int n;
        bcd_digits_t got;
        bcd_digits_t held;
        int unstable;
        k = 0;
        while (!bus.in_ready && k < 10) begin tick(); k++; end
        check("in_ready_before_accept", int'(bus.in_ready), 1);
        ena = 1'b1;
        bus.bin_in = v;
        bus.in_valid = 1'b1;
        exp_q.push_back(exp);
        tick();
        bus.in_valid = 1'b0;
        check("busy_after_accept", int'(bus.busy), 1);
        n = 0;
        while (!bus.out_valid && n < 60) begin
            ena = !(n >= off_at && n < off_at + off_len);
            if (inject && n == 2) begin
                bus.in_valid = 1'b1;
                bus.bin_in   = 8'd77;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            n++;
        end
        ena = 1'b1;
        bus.in_valid = 1'b0;
        check("latency", n, exp_lat);
        check("out_valid", int'(bus.out_valid), 1);
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
            return;
        end
        got = exp_q.pop_front();
        check("digits", int'(out_digits()), int'(got));
        held = out_digits();
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            bus.out_ready = 1'b0;
            tick();
            if (!bus.out_valid || out_digits() !== held) unstable++;
        end
        if (hold > 0) check("hold_stable_violations", unstable, 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("in_ready_after_handshake", int'(bus.in_ready), 1);
        check("out_valid_after_handshake", int'(bus.out_valid), 0);
        check("digits_retained", int'(out_digits()), int'(held));
    endtask

    initial begin
        bcd_digits_t e;
        vecs[0] = '{8'd0,   4'd0, 4'd0, 4'd0};
        vecs[1] = '{8'd255, 4'd2, 4'd5, 4'd5};
        vecs[2] = '{8'd99,  4'd0, 4'd9, 4'd9};
        vecs[3] = '{8'd100, 4'd1, 4'd0, 4'd0};
        vecs[4] = '{8'd9,   4'd0, 4'd0, 4'd9};
        vecs[5] = '{8'd10,  4'd0, 4'd1, 4'd0};
        vecs[6] = '{8'd199, 4'd1, 4'd9, 4'd9};
        vecs[7] = '{8'd58,  4'd0, 4'd5, 4'd8};

        rst_n = 1'b0;
        ena = 1'b1;
        bus.bin_in = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #22;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_digits", int'(out_digits()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table vectors; out_ready is held high during the conversion to show it is ignored.
        for (int i = 0; i < 8; i++) begin
            e.hundreds = vecs[i].h;
            e.tens     = vecs[i].t;
            e.ones     = vecs[i].o;
            if (i == 3) bus.out_ready = 1'b1;
            do_op(vecs[i].bin, e, 99, 0, 1'b0, 0, 8);
        end

        // Long hold in DONE.
        e = '{4'd1, 4'd2, 4'd3};
        do_op(8'd123, e, 99, 0, 1'b0, 20, 8);

        // Stray operand during SHIFT must be dropped.
        e = '{4'd0, 4'd1, 4'd3};
        do_op(8'd13, e, 99, 0, 1'b1, 0, 8);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_second_result", int'(bus.out_valid), 0);
        end

        // Reset at shift 4 aborts the conversion.
        ena = 1'b1;
        bus.bin_in = 8'd200;
        bus.in_valid = 1'b1;
        exp_q.push_back(model(200));
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #2;
        void'(exp_q.pop_back());
        check("abort_in_ready", int'(bus.in_ready), 1);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_digits", int'(out_digits()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        e = '{4'd0, 4'd4, 4'd2};
        do_op(8'd42, e, 99, 0, 1'b0, 0, 8);

        // Five disabled cycles mid-SHIFT stretch latency to 13.
        e = '{4'd1, 4'd8, 4'd7};
        do_op(8'd187, e, 3, 5, 1'b0, 0, 13);

        // Exhaustive sweep against the arithmetic reference.
        for (int v = 0; v < 256; v++) begin
            do_op(8'(v), model(v), 99, 0, 1'b0, 0, 8);
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/bin_to_bcd_serial.md
BIN_TO_BCD_SERIAL -- requirements
Module: bin_to_bcd_serial

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: ena  input  1  global enable; low freezes all state and outputs.
REQ-004 SHALL have port: bin_in  input  8  unsigned binary operand, 0..255.
REQ-005 SHALL have port: in_valid  input  1  bin_in is valid.
REQ-006 SHALL have port: in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port: bcd_hundreds  output  4  BCD hundreds digit, 0..2.
REQ-008 SHALL have port: bcd_tens  output  4  BCD tens digit, 0..9.
REQ-009 SHALL have port: bcd_ones  output  4  BCD ones digit, 0..9; feeds the downstream 7-segment decoder.
REQ-010 SHALL have port: out_valid  output  1  result digits are valid and held.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port: busy  output  1  conversion in progress (state SHIFT).

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-014 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE); busy SHALL equal (state==SHIFT); all are decoded from registered state only.
REQ-015 Acceptance: on an edge with ena=1, state=IDLE, in_valid=1, the block SHALL load bin_in into a 20-bit scratch register (12-bit BCD field cleared), clear the 3-bit iteration counter, and enter SHIFT.
REQ-016 In each SHIFT cycle with ena=1, every BCD nibble >=5 SHALL be incremented by 3, then the whole 20-bit scratch SHALL shift left by 1; the counter SHALL increment.
REQ-017 After the 8th shift (counter wrapping from 7), the block SHALL register the three BCD nibbles into the output digits and enter DONE in the same edge.
REQ-018 Latency SHALL be exactly 8 enabled cycles from the acceptance edge to out_valid=1.
REQ-019 In DONE, out_valid and the digits SHALL hold until an edge with out_ready=1 and ena=1, which returns the FSM to IDLE.
REQ-020 Output digits SHALL retain the last result after the handshake and change only at REQ-017.
REQ-021 in_valid during SHIFT or DONE SHALL be ignored; no operand is queued.
REQ-022 out_ready outside DONE SHALL have no effect.
REQ-023 ena=0 in any state SHALL hold state, counter, scratch and outputs unchanged; the cycle count of REQ-018 excludes these cycles.
REQ-024 No intermediate value SHALL appear on the digit outputs; no digit SHALL ever exceed 9.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, counter=0, scratch=0, all digits=0, so in_ready=1, out_valid=0, busy=0.
REQ-026 Reset asserted mid-conversion SHALL abort it; no result is produced, and the next operand after release is accepted normally.
REQ-027 Reset deassertion SHALL be synchronised to clk by the integrator; the block assumes no glitches on it.

Structure
REQ-028 A shared package SHALL hold BIN_W=8, DIGITS=3, BCD_W=4, ITER_CNT_W=3 and the FSM state enumeration.
REQ-029 The nibble adjust (>=5 then +3) SHALL be a sub-module, bcd_digit_adjust, instantiated once per digit.
REQ-030 All outputs SHALL be driven from flops or state decode, with no combinational path from inputs.

Verification
REQ-031 Operand 0 accepted -> after 8 cycles out_valid=1, digits 0/0/0.
REQ-032 Operand 255 -> digits 2/5/5; operand 99 -> 0/9/9; operand 100 -> 1/0/0; exhaustive sweep 0..255 matches a reference model.
REQ-033 out_ready held low 20 cycles in DONE -> out_valid and digits stable; in_ready returns 1 one cycle after the out_ready edge.
REQ-034 in_valid pulsed with 77 during SHIFT of operand 13 -> result is 0/1/3 and 77 is dropped.
REQ-035 rst_n low at shift 4 -> outputs 0, state IDLE; then operand 42 -> 0/4/2 after 8 cycles.
REQ-036 ena=0 for 5 cycles mid-SHIFT -> out_valid appears 13 cycles after acceptance with the correct digits.
